// File: rtl/udp_pkt_scheduler.sv
// udp_pkt_scheduler: paces fixed-length UDP payloads out of the camera line FIFO
// and tracks frame/packet sequence numbers across camera vsync.
module udp_pkt_scheduler #(
   parameter int PKT_LEN    = 1024,
   parameter int LEVEL_W    = 11,
   parameter int IFG_CYCLES = 64
) (
   input  logic               gmii_rx_clk,
   input  logic               rst,
   input  logic               cmos_vsync,
   input  logic [LEVEL_W-1:0] fifo_data_count,
   output logic               fifo_rd_en,
   output logic               udp_tx_req,
   input  logic               udp_tx_ack,
   input  logic               udp_tx_data_req,
   input  logic               udp_tx_done,
   output logic [15:0]        udp_send_data_length,
   output logic [15:0]        frame_id,
   output logic [15:0]        pkt_id,
   output logic               frame_start,
   output logic [15:0]        drop_cnt,
   output logic               busy
);
   localparam logic [15:0] LEN = 16'(PKT_LEN);
   localparam logic [15:0] IFG = 16'(IFG_CYCLES);

   typedef enum logic [2:0] {IDLE, REQ, SEND, WAIT_DONE, GAP} state_t;
   state_t state, state_nxt;

   logic        vs_s1, vs_s2, vs_s3, vs_rise, corrupt, done_lat;
   logic [15:0] byte_cnt, gap_cnt;
   logic        level_ok, done_evt, complete, dropped;

   assign udp_send_data_length = LEN;
   assign frame_start          = vs_rise;
   assign level_ok             = 32'(fifo_data_count) >= 32'(PKT_LEN);
   assign done_evt             = udp_tx_done || done_lat;
   assign complete             = state == WAIT_DONE && done_evt;
   // a vsync coinciding with completion still marks the packet as dropped
   assign dropped              = complete && (corrupt || vs_rise);

   always_ff @(posedge gmii_rx_clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (level_ok && !vs_rise) state_nxt = REQ;
         REQ:       if (udp_tx_ack) state_nxt = SEND; else if (vs_rise) state_nxt = IDLE;
         SEND:      if (byte_cnt == LEN) state_nxt = WAIT_DONE;
         WAIT_DONE: if (done_evt) state_nxt = GAP;
         GAP:       if (gap_cnt <= 16'd1) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      udp_tx_req = state == REQ;
      fifo_rd_en = state == SEND && udp_tx_data_req && byte_cnt < LEN;
      busy       = state != IDLE;
   end

   always_ff @(posedge gmii_rx_clk or posedge rst)
      if (rst) begin
         vs_s1    <= 1'b0;
         vs_s2    <= 1'b0;
         vs_s3    <= 1'b0;
         vs_rise  <= 1'b0;
         byte_cnt <= '0;
         gap_cnt  <= '0;
         done_lat <= 1'b0;
         corrupt  <= 1'b0;
         frame_id <= '0;
         pkt_id   <= '0;
         drop_cnt <= '0;
      end else begin
         vs_s1    <= cmos_vsync;
         vs_s2    <= vs_s1;
         vs_s3    <= vs_s2;
         vs_rise  <= vs_s2 & ~vs_s3;
         byte_cnt <= (state == REQ && udp_tx_ack) ? '0 : fifo_rd_en ? byte_cnt + 16'd1 : byte_cnt;
         gap_cnt  <= complete ? IFG : state == GAP ? gap_cnt - 16'd1 : gap_cnt;
         // an early done during SEND is held until WAIT_DONE consumes it
         done_lat <= state == SEND && (done_lat || udp_tx_done);
         if (complete)
            corrupt <= 1'b0;
         else if (vs_rise && (state == SEND || state == WAIT_DONE || (state == REQ && udp_tx_ack)))
            corrupt <= 1'b1;
         frame_id <= frame_id + 16'(vs_rise);
         if (vs_rise)
            pkt_id <= '0;
         else if (complete && !corrupt)
            pkt_id <= pkt_id + 16'd1;
         if (dropped && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
      end
endmodule

// File: tb/tb_udp_pkt_scheduler.sv
// tb_udp_pkt_scheduler: scenario tasks against a counting model of frames,
// packets and drops, with randomized read throttling.
module tb_udp_pkt_scheduler;
   localparam int PKT_LEN = 1024;
   localparam int IFG     = 64;

   logic        gmii_rx_clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmos_vsync = 1'b0;
   logic [10:0] fifo_data_count = '0;
   logic        udp_tx_ack = 1'b0;
   logic        udp_tx_data_req = 1'b0;
   logic        udp_tx_done = 1'b0;
   logic        fifo_rd_en, udp_tx_req, frame_start, busy;
   logic [15:0] udp_send_data_length, frame_id, pkt_id, drop_cnt;

   int tests = 0, fails = 0;
   int rd_total = 0, bad_rd = 0, fs_total = 0, cyc = 0, done_cyc = 0;
   int exp_frame = 0, exp_pkt = 0, exp_drop = 0;

   udp_pkt_scheduler dut (
      .gmii_rx_clk(gmii_rx_clk), .rst(rst), .cmos_vsync(cmos_vsync),
      .fifo_data_count(fifo_data_count), .fifo_rd_en(fifo_rd_en),
      .udp_tx_req(udp_tx_req), .udp_tx_ack(udp_tx_ack),
      .udp_tx_data_req(udp_tx_data_req), .udp_tx_done(udp_tx_done),
      .udp_send_data_length(udp_send_data_length), .frame_id(frame_id),
      .pkt_id(pkt_id), .frame_start(frame_start), .drop_cnt(drop_cnt), .busy(busy)
   );

   always #4 gmii_rx_clk = ~gmii_rx_clk;

   always @(posedge gmii_rx_clk) begin
      cyc      <= cyc + 1;
      rd_total <= rd_total + int'(fifo_rd_en);
      bad_rd   <= bad_rd + int'(fifo_rd_en && (!udp_tx_data_req || !busy));
      fs_total <= fs_total + int'(frame_start);
   end

   task automatic check_ids(input string tag);
      tests++;
      if (frame_id !== 16'(exp_frame) || pkt_id !== 16'(exp_pkt) || drop_cnt !== 16'(exp_drop)) begin
         fails++;
         $display("FAIL %s ids: frame/pkt/drop got %0d/%0d/%0d expected %0d/%0d/%0d",
                  tag, frame_id, pkt_id, drop_cnt, exp_frame, exp_pkt, exp_drop);
      end
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge gmii_rx_clk);
         if (udp_tx_req) ok = 1'b1;
      end
      tests++;
      if (!ok) begin fails++; $display("FAIL req_timeout: udp_tx_req got 0 expected 1"); end
   endtask

   task automatic send_pkt(input bit throttle, input int vs_at);
      int start, vt;
      bit ok;
      wait_req(ok);
      if (!ok) return;
      repeat (2) @(negedge gmii_rx_clk);
      udp_tx_ack = 1'b1;
      @(negedge gmii_rx_clk);
      udp_tx_ack = 1'b0;
      tests++;
      if (udp_tx_req !== 1'b0) begin fails++; $display("FAIL req_after_ack: got %b expected 0", udp_tx_req); end
      start = rd_total;
      vt = -1;
      for (int i = 0; i < 20000 && rd_total - start < PKT_LEN; i++) begin
         udp_tx_data_req = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
         if (vs_at >= 0 && vt < 0 && rd_total - start >= vs_at) begin
            cmos_vsync = 1'b1;
            vt = 0;
         end else if (vt >= 0 && vt < 6) begin
            vt++;
            if (vt == 6) cmos_vsync = 1'b0;
         end
         @(negedge gmii_rx_clk);
      end
      udp_tx_data_req = 1'b1;
      repeat (12) @(negedge gmii_rx_clk);
      cmos_vsync = 1'b0;
      tests++;
      if (rd_total - start !== PKT_LEN) begin
         fails++;
         $display("FAIL rd_count: got %0d expected %0d", rd_total - start, PKT_LEN);
      end
      udp_tx_data_req = 1'b0;
      udp_tx_done = 1'b1;
      done_cyc = cyc;
      @(negedge gmii_rx_clk);
      udp_tx_done = 1'b0;
      if (vs_at >= 0) begin exp_frame++; exp_pkt = 0; exp_drop++; end
      else exp_pkt++;
      repeat (2) @(negedge gmii_rx_clk);
      check_ids("after_done");
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge gmii_rx_clk);
      tests++;
      if ({fifo_rd_en, udp_tx_req, frame_start, busy} !== 4'b0) begin
         fails++;
         $display("FAIL reset_ctrl: rd/req/fs/busy got %b expected 0000", {fifo_rd_en, udp_tx_req, frame_start, busy});
      end
      check_ids("reset");
      tests++;
      if (udp_send_data_length !== 16'(PKT_LEN)) begin
         fails++;
         $display("FAIL length: got %0d expected %0d", udp_send_data_length, PKT_LEN);
      end
      rst = 1'b0;
      @(negedge gmii_rx_clk);
   endtask

   task automatic test_single_packet;
      bit ok;
      fifo_data_count = 11'(PKT_LEN);
      send_pkt(1'b0, -1);
      wait_req(ok);
      tests++;
      if (ok && (cyc - done_cyc < IFG + 2 || cyc - done_cyc > IFG + 4)) begin
         fails++;
         $display("FAIL ifg_spacing: got %0d cycles expected %0d", cyc - done_cyc, IFG + 2);
      end
   endtask

   task automatic test_back_to_back;
      send_pkt(1'b0, -1);
   endtask

   task automatic test_below_threshold;
      int bad = 0;
      fifo_data_count = 11'(PKT_LEN - 1);
      for (int i = 0; i < 200 && busy; i++) @(negedge gmii_rx_clk);
      for (int i = 0; i < 5000; i++) begin
         @(negedge gmii_rx_clk);
         if (udp_tx_req || busy) bad++;
      end
      tests++;
      if (bad != 0) begin fails++; $display("FAIL below_threshold: busy cycles got %0d expected 0", bad); end
   endtask

   task automatic test_throttled;
      fifo_data_count = 11'(PKT_LEN);
      send_pkt(1'b1, -1);
      tests++;
      if (bad_rd != 0) begin fails++; $display("FAIL rd_gating: stray reads got %0d expected 0", bad_rd); end
   endtask

   task automatic test_vsync_req;
      bit ok;
      int fs0;
      fifo_data_count = 11'(PKT_LEN);
      for (int i = 0; i < 200 && busy; i++) @(negedge gmii_rx_clk);
      wait_req(ok);
      fs0 = fs_total;
      fifo_data_count = '0;
      cmos_vsync = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge gmii_rx_clk);
         if (!udp_tx_req) ok = 1'b1;
      end
      cmos_vsync = 1'b0;
      exp_frame++;
      exp_pkt = 0;
      tests++;
      if (!ok) begin fails++; $display("FAIL req_withdraw: udp_tx_req got 1 expected 0"); end
      @(negedge gmii_rx_clk);
      check_ids("vsync_req");
      udp_tx_ack = 1'b1;
      @(negedge gmii_rx_clk);
      udp_tx_ack = 1'b0;
      repeat (3) @(negedge gmii_rx_clk);
      tests++;
      if (busy !== 1'b0 || fs_total - fs0 != 1) begin
         fails++;
         $display("FAIL stray_ack: busy/frame_starts got %b/%0d expected 0/1", busy, fs_total - fs0);
      end
   endtask

   task automatic test_vsync_send;
      int fs0 = fs_total;
      fifo_data_count = 11'(PKT_LEN);
      send_pkt(1'b0, 500);
      tests++;
      if (fs_total - fs0 != 1) begin
         fails++;
         $display("FAIL frame_start: pulses got %0d expected 1", fs_total - fs0);
      end
   endtask

   task automatic test_reset_mid_send;
      bit ok;
      int start;
      for (int i = 0; i < 200 && busy; i++) @(negedge gmii_rx_clk);
      wait_req(ok);
      repeat (2) @(negedge gmii_rx_clk);
      udp_tx_ack = 1'b1;
      @(negedge gmii_rx_clk);
      udp_tx_ack = 1'b0;
      udp_tx_data_req = 1'b1;
      start = rd_total;
      for (int i = 0; i < 2000 && rd_total - start < 300; i++) @(negedge gmii_rx_clk);
      rst = 1'b1;
      #1;
      tests++;
      if ({fifo_rd_en, udp_tx_req, busy} !== 3'b0) begin
         fails++;
         $display("FAIL reset_mid_send: rd/req/busy got %b expected 000", {fifo_rd_en, udp_tx_req, busy});
      end
      exp_frame = 0;
      exp_pkt = 0;
      exp_drop = 0;
      check_ids("reset_mid_send");
      @(negedge gmii_rx_clk);
      udp_tx_data_req = 1'b0;
      rst = 1'b0;
      send_pkt(1'b1, -1);
   endtask

   initial begin
      test_reset;
      test_single_packet;
      test_back_to_back;
      test_below_threshold;
      test_throttled;
      test_vsync_req;
      test_vsync_send;
      test_reset_mid_send;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
